// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: walks pcAddress over the four bytes of a word,
// assembles them little-endian and presents the word to decode under valid/ready.

module instruction_fetch_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dout <= '0;
    else if (capture) dout <= din;
  end
endmodule

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pcAddress,
  input  logic [31:0] pcDataOutput,
  input  logic        halt,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] instruction,
  output logic [31:0] instructionPc,
  output logic        instrValid,
  input  logic        instrReady,
  output logic        addrError
);
  localparam int NUM_LANES = 3;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t                       state, state_next;
  logic [31:0]                  pc, pc_next;
  logic [1:0]                   byte_idx, byte_idx_next;
  logic                         capture, complete, accept;
  logic [NUM_LANES-1:0][7:0]    buffer;
  logic [7:0]                   mem_byte;
  logic                         unused_data_hi;

  assign mem_byte       = pcDataOutput[7:0];
  assign unused_data_hi = ^pcDataOutput[31:8];

  // The top byte is never buffered: it goes straight into the instruction
  // register on the completing edge, so only three capture lanes exist.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    instruction_fetch_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .capture (capture && (byte_idx == 2'(i))),
      .din     (mem_byte),
      .dout    (buffer[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      byte_idx <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      byte_idx <= byte_idx_next;
    end
  end

  // Redirect takes priority over halt, assembly progress and handshake.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    byte_idx_next = byte_idx;
    capture       = 1'b0;
    complete      = 1'b0;
    accept        = 1'b0;
    if (branchTaken) begin
      state_next    = FETCH;
      pc_next       = {branchTarget[31:2], 2'b00};
      byte_idx_next = '0;
    end else begin
      case (state)
        FETCH: begin
          if (!halt) begin
            capture       = 1'b1;
            byte_idx_next = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              complete   = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (instrValid && instrReady) begin
            accept        = 1'b1;
            pc_next       = pc + 32'd4;
            byte_idx_next = '0;
            state_next    = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction   <= '0;
      instructionPc <= '0;
      instrValid    <= 1'b0;
      addrError     <= 1'b0;
    end else begin
      if (complete) begin
        instruction   <= {mem_byte, buffer[2], buffer[1], buffer[0]};
        instructionPc <= pc;
      end
      if (branchTaken)   instrValid <= 1'b0;
      else if (complete) instrValid <= 1'b1;
      else if (accept)   instrValid <= 1'b0;
      if (branchTaken && (branchTarget[1:0] != 2'b00)) addrError <= 1'b1;
    end
  end

  // Purely a function of registered state, so no input reaches it combinationally.
  assign pcAddress = (state == HOLD) ? pc : pc + {30'd0, byte_idx};

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner
// sequences, then randomized traffic against a word-level reference model.

module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcAddress;
  logic [31:0] pcDataOutput;
  logic        halt = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic [31:0] instruction;
  logic [31:0] instructionPc;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic        addrError;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .pcAddress     (pcAddress),
    .pcDataOutput  (pcDataOutput),
    .halt          (halt),
    .branchTaken   (branchTaken),
    .branchTarget  (branchTarget),
    .instruction   (instruction),
    .instructionPc (instructionPc),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .addrError     (addrError)
  );

  function automatic logic [7:0] mem(input logic [31:0] a);
    case (a)
      32'd0: return 8'h78;
      32'd1: return 8'h56;
      32'd2: return 8'h34;
      32'd3: return 8'h12;
      32'd4: return 8'hEF;
      32'd5: return 8'hBE;
      32'd6: return 8'hAD;
      32'd7: return 8'hDE;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem(a + 32'd3), mem(a + 32'd2), mem(a + 32'd1), mem(a)};
  endfunction

  // Upper bits carry junk so that only the low byte may matter.
  assign pcDataOutput = {pcAddress[31:8] ^ 24'h5A_A55A, mem(pcAddress)};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; applies inputs across one rising edge, returns at the next negedge.
  task automatic drive(input logic h, input logic b, input logic [31:0] t, input logic r);
    halt = h; branchTaken = b; branchTarget = t; instrReady = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        h, b, r;
    logic [31:0] t;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr, e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vt[10];

  task automatic run_vec(input int i);
    chk($sformatf("vec%0d pcAddress", i),     pcAddress,     vt[i].e_addr);
    chk($sformatf("vec%0d instrValid", i),    {31'd0, instrValid}, {31'd0, vt[i].e_vld});
    chk($sformatf("vec%0d instruction", i),   instruction,   vt[i].e_instr);
    chk($sformatf("vec%0d instructionPc", i), instructionPc, vt[i].e_ipc);
    chk($sformatf("vec%0d addrError", i),     {31'd0, addrError}, {31'd0, vt[i].e_err});
    drive(vt[i].h, vt[i].b, vt[i].t, vt[i].r);
  endtask

  // Reference model: state as "bytes consumed so far" plus a held word.
  logic [31:0] m_pc, m_instr, m_ipc;
  int          m_cnt;
  logic        m_valid, m_err;

  initial begin
    // inputs: h b r t | expected before the edge: addr vld instr ipc err
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 32'h0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h5, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h6, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h7, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vt[9] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1, 32'hDEAD_BEEF, 32'h4, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic fetch of the first word, then backpressure.
    for (int i = 0; i < 5; i++) run_vec(i);
    for (int i = 0; i < 10; i++) begin
      chk("bp instrValid", {31'd0, instrValid}, 32'd1);
      chk("bp instruction", instruction, 32'h1234_5678);
      chk("bp instructionPc", instructionPc, 32'h0);
      chk("bp pcAddress", pcAddress, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 5; i < 10; i++) run_vec(i);

    // Redirect mid-fetch at byte index 2 of the word at 8.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir pre pcAddress", pcAddress, 32'hA);
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    chk("redir pcAddress", pcAddress, 32'h100);
    chk("redir instrValid", {31'd0, instrValid}, 32'd0);
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir early instrValid", {31'd0, instrValid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir instrValid", {31'd0, instrValid}, 32'd1);
    chk("redir instructionPc", instructionPc, 32'h100);
    chk("redir instruction", instruction, word_at(32'h100));

    // Misaligned target, then an aligned one: flag is sticky.
    drive(1'b0, 1'b1, 32'h103, 1'b0);
    chk("misal pcAddress", pcAddress, 32'h100);
    chk("misal addrError", {31'd0, addrError}, 32'd1);
    chk("misal instrValid", {31'd0, instrValid}, 32'd0);
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    chk("sticky pcAddress", pcAddress, 32'h200);
    chk("sticky addrError", {31'd0, addrError}, 32'd1);

    // Halt for 3 cycles at byte index 1.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      chk("halt pcAddress", pcAddress, 32'h201);
      chk("halt instrValid", {31'd0, instrValid}, 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("halt late instrValid", {31'd0, instrValid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("halt instrValid", {31'd0, instrValid}, 32'd1);
    chk("halt instructionPc", instructionPc, 32'h200);
    chk("halt instruction", instruction, word_at(32'h200));

    // Handshake, then branch while halted.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("hs pcAddress", pcAddress, 32'h204);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    chk("halt br pcAddress", pcAddress, 32'h300);
    chk("halt br instrValid", {31'd0, instrValid}, 32'd0);

    // Async reset while holding a word.
    repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre-rst instrValid", {31'd0, instrValid}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst instrValid", {31'd0, instrValid}, 32'd0);
    chk("arst instruction", instruction, 32'h0);
    chk("arst instructionPc", instructionPc, 32'h0);
    chk("arst pcAddress", pcAddress, 32'h0);
    chk("arst addrError", {31'd0, addrError}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    m_pc = 32'h0; m_cnt = 0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic        h, b, r;
      logic [31:0] t;
      chk("rnd pcAddress", pcAddress, m_valid ? m_pc : m_pc + 32'(m_cnt));
      chk("rnd instrValid", {31'd0, instrValid}, {31'd0, m_valid});
      chk("rnd instruction", instruction, m_instr);
      chk("rnd instructionPc", instructionPc, m_ipc);
      chk("rnd addrError", {31'd0, addrError}, {31'd0, m_err});
      h = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 9) < 6);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t[31:4] = 28'hFFF_FFFF;
      drive(h, b, t, r);
      if (b) begin
        m_pc = {t[31:2], 2'b00};
        m_cnt = 0;
        m_valid = 1'b0;
        if (t[1:0] != 2'b00) m_err = 1'b1;
      end else if (m_valid) begin
        if (r) begin
          m_pc = m_pc + 32'd4;
          m_cnt = 0;
          m_valid = 1'b0;
        end
      end else if (!h) begin
        if (m_cnt == 3) begin
          m_instr = word_at(m_pc);
          m_ipc = m_pc;
          m_valid = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
